// File: rtl/arbitro_mux4_rr.sv
// Round-robin arbiter/sequencer sharing a 4:1 datapath mux among four burst requesters.
// Latency: request seen in idle -> grant next edge -> beat same cycle -> SaidaValida one edge later.
// Backpressure: Pronto low with SaidaValida high freezes the output register, beat counter and acceptance.
module arbitro_mux4_rr #(
    parameter int LARGURA    = 8,
    parameter int MAX_RAJADA = 4
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic [3:0]         Req,
    input  logic [3:0]         Ultimo,
    input  logic [LARGURA-1:0] Dado0,
    input  logic [LARGURA-1:0] Dado1,
    input  logic [LARGURA-1:0] Dado2,
    input  logic [LARGURA-1:0] Dado3,
    input  logic               Pronto,
    output logic [3:0]         Gnt,
    output logic [1:0]         Selecao,
    output logic [3:0]         Aceito,
    output logic [LARGURA-1:0] SaidaDado,
    output logic               SaidaValida
);

    localparam int CW = $clog2(MAX_RAJADA) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_RAJADA - 1);

    typedef enum logic {
        OCIOSO    = 1'b0,
        CONCEDIDO = 1'b1
    } estado_t;

    estado_t            estado_q, estado_d;
    logic [3:0]         gnt_q, gnt_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [LARGURA-1:0] dado_q, dado_d;
    logic               vld_q, vld_d;

    logic [LARGURA-1:0] dado_mux;
    logic               beat;
    logic               venc_ok;
    logic [1:0]         venc;
    logic [1:0]         cand;
    logic               libera;

    always_comb begin
        dado_mux = Dado0;
        case (sel_q)
            2'd0: dado_mux = Dado0;
            2'd1: dado_mux = Dado1;
            2'd2: dado_mux = Dado2;
            2'd3: dado_mux = Dado3;
            default: dado_mux = Dado0;
        endcase
    end

    // Search starts just after the last winner, so the releasing requester ends up last.
    always_comb begin
        venc_ok = 1'b0;
        venc    = 2'd0;
        cand    = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!venc_ok && Req[cand]) begin
                venc_ok = 1'b1;
                venc    = cand;
            end
        end
    end

    assign beat   = (estado_q == CONCEDIDO) && Req[sel_q] && (!vld_q || Pronto);
    assign Aceito = gnt_q & {4{beat}};
    assign libera = !Req[sel_q] || (beat && (Ultimo[sel_q] || (cnt_q == CNT_MAX)));

    always_comb begin
        estado_d = estado_q;
        gnt_d    = gnt_q;
        sel_d    = sel_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        dado_d   = dado_q;
        vld_d    = vld_q;

        if (beat) begin
            dado_d = dado_mux;
            vld_d  = 1'b1;
        end else if (vld_q && Pronto) begin
            vld_d = 1'b0;
        end

        case (estado_q)
            OCIOSO: begin
                if (venc_ok) begin
                    gnt_d    = 4'b0001 << venc;
                    sel_d    = venc;
                    cnt_d    = '0;
                    estado_d = CONCEDIDO;
                end else begin
                    gnt_d = 4'b0000;
                end
            end
            CONCEDIDO: begin
                if (libera) begin
                    gnt_d    = 4'b0000;
                    ptr_d    = sel_q;
                    cnt_d    = '0;
                    estado_d = OCIOSO;
                end else if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                gnt_d    = 4'b0000;
                cnt_d    = '0;
                estado_d = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            estado_q <= OCIOSO;
            gnt_q    <= 4'b0000;
            sel_q    <= 2'd0;
            ptr_q    <= 2'd3;
            cnt_q    <= '0;
            dado_q   <= '0;
            vld_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            gnt_q    <= gnt_d;
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            dado_q   <= dado_d;
            vld_q    <= vld_d;
        end
    end

    assign Gnt         = gnt_q;
    assign Selecao     = sel_q;
    assign SaidaDado   = dado_q;
    assign SaidaValida = vld_q;

endmodule

// File: tb/tb_arbitro_mux4_rr.sv
// Directed bench for arbitro_mux4_rr: per-requester producer model, expected beats/grants queued
// at stimulus time and popped by an independent negedge monitor.
module tb_arbitro_mux4_rr;

    logic       Clock = 1'b0;
    logic       Reset_n = 1'b1;
    logic [3:0] Req = 4'b0;
    logic [3:0] Ultimo = 4'b0;
    logic [7:0] Dado0 = 8'h0, Dado1 = 8'h0, Dado2 = 8'h0, Dado3 = 8'h0;
    logic       Pronto = 1'b1;
    logic [3:0] Gnt;
    logic [1:0] Selecao;
    logic [3:0] Aceito;
    logic [7:0] SaidaDado;
    logic       SaidaValida;

    arbitro_mux4_rr #(.LARGURA(8), .MAX_RAJADA(4)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Req(Req), .Ultimo(Ultimo),
        .Dado0(Dado0), .Dado1(Dado1), .Dado2(Dado2), .Dado3(Dado3),
        .Pronto(Pronto), .Gnt(Gnt), .Selecao(Selecao), .Aceito(Aceito),
        .SaidaDado(SaidaDado), .SaidaValida(SaidaValida)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_dat[$];
    int         exp_idx[$];
    int         exp_gap[$];

    // Producer model: rem = beats left, lmode 0 never last, 1 last on final beat, 2 every beat last.
    int         rem[4];
    int         lmode[4];
    logic [7:0] dv[4];
    int         acc_cnt[4];

    logic [3:0] s_gnt, s_acc;
    logic [1:0] s_sel;
    logic [7:0] s_dat;
    logic       s_vld;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            Req[i]    = (rem[i] > 0);
            Ultimo[i] = (rem[i] > 0) && ((lmode[i] == 2) || (lmode[i] == 1 && rem[i] == 1));
        end
        Dado0 = dv[0];
        Dado1 = dv[1];
        Dado2 = dv[2];
        Dado3 = dv[3];
    endtask

    task automatic step();
        @(negedge Clock);
        s_gnt = Gnt;
        s_acc = Aceito;
        s_sel = Selecao;
        s_dat = SaidaDado;
        s_vld = SaidaValida;
        @(posedge Clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (s_acc[i]) begin
                if (rem[i] > 0) rem[i]--;
                dv[i]++;
                acc_cnt[i]++;
            end
        end
        drive();
    endtask

    task automatic clear_producers();
        for (int i = 0; i < 4; i++) begin
            rem[i]     = 0;
            lmode[i]   = 0;
            acc_cnt[i] = 0;
        end
        drive();
    endtask

    task automatic do_reset();
        Pronto = 1'b1;
        clear_producers();
        Reset_n = 1'b0;
        #2;
        chk("rst_gnt", Gnt, 4'b0000);
        chk("rst_selecao", Selecao, 2'd0);
        chk("rst_saidadado", SaidaDado, 8'h00);
        chk("rst_saidavalida", SaidaValida, 1'b0);
        chk("rst_aceito", Aceito, 4'b0000);
        @(negedge Clock);
        #1;
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_acc(input int i, input int n);
        int k = 0;
        while (acc_cnt[i] < n && k < 100) begin
            step();
            k++;
        end
        checks++;
        if (acc_cnt[i] < n) begin
            errors++;
            $display("FAIL wait_acc: requester %0d accepted %0d beats, expected %0d", i, acc_cnt[i], n);
        end
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (k < 200 && !(exp_dat.size() == 0 && exp_idx.size() == 0 &&
                            (rem[0] + rem[1] + rem[2] + rem[3]) == 0 && s_gnt == 4'b0 && !s_vld)) begin
            step();
            k++;
        end
        checks++;
        if (k >= 200) begin
            errors++;
            $display("FAIL %s_timeout: %0d beats and %0d grants still outstanding, expected 0",
                     name, exp_dat.size(), exp_idx.size());
            exp_dat.delete();
            exp_idx.delete();
            exp_gap.delete();
        end
        step();
        step();
    endtask

    task automatic push_grant(input int idx, input int gap);
        exp_idx.push_back(idx);
        exp_gap.push_back(gap);
    endtask

    // Monitor: grants and consumed beats are compared against the queues.
    logic [3:0] m_prev_gnt = 4'b0;
    int         m_gap = 0;
    int         m_idx, m_egap;
    logic [7:0] m_dat;

    always @(negedge Clock) begin
        if (!Reset_n) begin
            m_prev_gnt = 4'b0;
            m_gap      = 0;
        end else begin
            if (Aceito != 4'b0) chk("aceito_within_gnt", Aceito, Gnt);
            if (Gnt != 4'b0 && m_prev_gnt == 4'b0) begin
                if (exp_idx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got %b, expected none", Gnt);
                end else begin
                    m_idx  = exp_idx.pop_front();
                    m_egap = exp_gap.pop_front();
                    chk("grant_onehot", Gnt, 4'b0001 << m_idx);
                    chk("grant_selecao", Selecao, m_idx);
                    if (m_egap >= 0) chk("grant_idle_gap", m_gap, m_egap);
                end
            end else if (Gnt != 4'b0 && m_prev_gnt != 4'b0 && Gnt != m_prev_gnt) begin
                checks++;
                errors++;
                $display("FAIL grant_no_idle: got %b after %b, expected an idle cycle", Gnt, m_prev_gnt);
            end
            if (Gnt == 4'b0) m_gap++;
            else m_gap = 0;
            if (SaidaValida && Pronto) begin
                if (exp_dat.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h, expected none", SaidaDado);
                end else begin
                    m_dat = exp_dat.pop_front();
                    chk("beat_data", SaidaDado, m_dat);
                end
            end
            m_prev_gnt = Gnt;
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) dv[i] = 8'h00;
        clear_producers();
        #1;

        // 1: single beat from requester 0 straight after reset
        do_reset();
        dv[0] = 8'hA5; rem[0] = 1; lmode[0] = 2;
        exp_dat.push_back(8'hA5);
        push_grant(0, -1);
        drive();
        step();
        chk("t1_gnt_c0", s_gnt, 4'b0000);
        step();
        chk("t1_gnt_c1", s_gnt, 4'b0001);
        chk("t1_aceito_c1", s_acc, 4'b0001);
        chk("t1_sel_c1", s_sel, 2'd0);
        step();
        chk("t1_vld_c2", s_vld, 1'b1);
        chk("t1_dat_c2", s_dat, 8'hA5);
        chk("t1_gnt_c2", s_gnt, 4'b0000);
        wait_idle("t1");

        // 2: all four requesting with Ultimo set -> 0,1,2,3,0, one idle cycle apart
        do_reset();
        dv[0] = 8'h10; dv[1] = 8'h20; dv[2] = 8'h30; dv[3] = 8'h40;
        rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
        for (int i = 0; i < 4; i++) lmode[i] = 2;
        push_grant(0, -1); push_grant(1, 1); push_grant(2, 1); push_grant(3, 1); push_grant(0, 1);
        exp_dat.push_back(8'h10); exp_dat.push_back(8'h20); exp_dat.push_back(8'h30);
        exp_dat.push_back(8'h40); exp_dat.push_back(8'h11);
        drive();
        wait_idle("t2");

        // 3: sole requester 1 without Ultimo -> bursts capped at 4 beats, re-granted after idle
        dv[1] = 8'd1; rem[1] = 6; lmode[1] = 0;
        push_grant(1, -1); push_grant(1, 1);
        for (int b = 1; b <= 6; b++) exp_dat.push_back(8'(b));
        drive();
        wait_idle("t3");

        // 4: consumer stalls for 3 cycles mid-burst
        clear_producers();
        dv[2] = 8'h50; rem[2] = 4; lmode[2] = 1;
        push_grant(2, -1);
        for (int b = 0; b < 4; b++) exp_dat.push_back(8'h50 + 8'(b));
        drive();
        wait_acc(2, 2);
        Pronto = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk("t4_stall_vld", s_vld, 1'b1);
            chk("t4_stall_dat", s_dat, 8'h51);
            chk("t4_stall_aceito", s_acc, 4'b0000);
        end
        Pronto = 1'b1;
        wait_idle("t4");

        // 5: requester 2 drops Req after one beat, requester 3 takes over after idle
        do_reset();
        dv[2] = 8'h60; rem[2] = 1; lmode[2] = 0;
        dv[3] = 8'h70; rem[3] = 1; lmode[3] = 2;
        push_grant(2, -1); push_grant(3, 1);
        exp_dat.push_back(8'h60); exp_dat.push_back(8'h70);
        drive();
        wait_idle("t5");

        // 6: asynchronous reset in the middle of a burst from requester 1
        clear_producers();
        dv[1] = 8'h80; rem[1] = 4; lmode[1] = 0;
        push_grant(1, -1);
        exp_dat.push_back(8'h80);
        drive();
        wait_acc(1, 2);
        chk("t6_pre_gnt", Gnt, 4'b0010);
        chk("t6_pre_vld", SaidaValida, 1'b1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("t6_async_gnt", Gnt, 4'b0000);
        chk("t6_async_vld", SaidaValida, 1'b0);
        chk("t6_async_dat", SaidaDado, 8'h00);
        chk("t6_async_sel", Selecao, 2'd0);
        clear_producers();
        @(negedge Clock);
        #1;
        Reset_n = 1'b1;
        @(posedge Clock);
        #1;
        dv[0] = 8'h90; rem[0] = 1; lmode[0] = 2;
        dv[1] = 8'hA0; rem[1] = 1; lmode[1] = 2;
        push_grant(0, -1); push_grant(1, 1);
        exp_dat.push_back(8'h90); exp_dat.push_back(8'hA0);
        drive();
        wait_idle("t6");

        chk("leftover_expectations", exp_dat.size() + exp_idx.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
